// File: rtl/status_poller_if.sv
// Signal bundle for the status poller: single-cycle register read bus plus the
// indexed result stream. The poller uses the master view, responders/sinks the slave view.
interface status_poller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) ();
  logic [ADDR_WIDTH-1:0] ps_addr;
  logic                  ps_rden;
  logic [DATA_WIDTH-1:0] ps_rdat;
  logic                  ps_rvld;

  logic [DATA_WIDTH-1:0] odata;
  logic [IDX_WIDTH-1:0]  oidx;
  logic                  oerr;
  logic                  ovld;
  logic                  iready;

  modport master (
    output ps_addr, ps_rden,
    input  ps_rdat, ps_rvld,
    output odata, oidx, oerr, ovld,
    input  iready
  );

  modport slave (
    input  ps_addr, ps_rden,
    output ps_rdat, ps_rvld,
    input  odata, oidx, oerr, ovld,
    output iready
  );
endinterface

// File: rtl/status_poller.sv
// Sweeps NUM_REGS register addresses over the read bus on a start pulse and
// streams each returned word (or a timeout marker) out with its index.
module status_poller #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 4,
  parameter int                    IDX_WIDTH   = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(4),
  parameter int                    TIMEOUT     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                istart,
  status_poller_if.master     bus,
  output logic                obusy,
  output logic                odone,
  output logic                oerr_any
);

  localparam int                    WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, READ, PUSH, DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [IDX_WIDTH-1:0]  oidx_q, oidx_d;
  logic                  oerr_q, oerr_d;
  logic                  ovld_q, ovld_d;
  logic                  obusy_q, obusy_d;
  logic                  odone_q, odone_d;
  logic                  oerr_any_q, oerr_any_d;
  logic [ADDR_WIDTH-1:0] ps_addr_q, ps_addr_d;
  logic                  ps_rden_q, ps_rden_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    odata_d    = odata_q;
    oidx_d     = oidx_q;
    oerr_d     = oerr_q;
    oerr_any_d = oerr_any_q;

    case (state_q)
      IDLE: begin
        if (istart) begin
          idx_d      = '0;
          wait_d     = '0;
          oerr_any_d = 1'b0;
          state_d    = READ;
        end
      end
      READ: begin
        // A response in the final wait cycle still beats the timeout.
        if (bus.ps_rvld) begin
          odata_d = bus.ps_rdat;
          oerr_d  = 1'b0;
          oidx_d  = idx_q;
          state_d = PUSH;
        end else if (wait_q == WAIT_LAST) begin
          odata_d    = '0;
          oerr_d     = 1'b1;
          oidx_d     = idx_q;
          oerr_any_d = 1'b1;
          state_d    = PUSH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      PUSH: begin
        if (bus.iready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            wait_d  = '0;
            state_d = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    ps_rden_d = (state_d == READ);
    ps_addr_d = ps_rden_d ? (BASE_ADDR + ADDR_WIDTH'(idx_d) * ADDR_STRIDE) : '0;
    ovld_d    = (state_d == PUSH);
    obusy_d   = (state_d == READ) || (state_d == PUSH);
    odone_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      odata_q    <= '0;
      oidx_q     <= '0;
      oerr_q     <= 1'b0;
      ovld_q     <= 1'b0;
      obusy_q    <= 1'b0;
      odone_q    <= 1'b0;
      oerr_any_q <= 1'b0;
      ps_addr_q  <= '0;
      ps_rden_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      odata_q    <= odata_d;
      oidx_q     <= oidx_d;
      oerr_q     <= oerr_d;
      ovld_q     <= ovld_d;
      obusy_q    <= obusy_d;
      odone_q    <= odone_d;
      oerr_any_q <= oerr_any_d;
      ps_addr_q  <= ps_addr_d;
      ps_rden_q  <= ps_rden_d;
    end
  end

  assign bus.ps_addr = ps_addr_q;
  assign bus.ps_rden = ps_rden_q;
  assign bus.odata   = odata_q;
  assign bus.oidx    = oidx_q;
  assign bus.oerr    = oerr_q;
  assign bus.ovld    = ovld_q;
  assign obusy       = obusy_q;
  assign odone       = odone_q;
  assign oerr_any    = oerr_any_q;

endmodule
